// File: rtl/demux_wr.sv
// Write-side demux: routes din into one of eight holding registers, singly or as an
// auto-incrementing burst, with per-slot valid flags and a busy/done handshake.
module demux_wr #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write,
  input  logic             burst,
  input  logic [2:0]       s,
  input  logic [2:0]       len,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic [7:0]       valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_e;

  state_e                 state_q, state_d;
  logic [7:0][WIDTH-1:0]  slot_q, slot_d;
  logic [7:0]             valid_q, valid_d;
  logic [2:0]             ptr_q, ptr_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   wr_en;
  logic [2:0]             wr_idx;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    case (state_q)
      IDLE: begin
        if (write) begin
          wr_en  = 1'b1;
          wr_idx = s;
          if (burst) begin
            ptr_d   = s + 3'd1;
            cnt_d   = len;
            state_d = (len == 3'd0) ? DONE : BURST;
          end
        end
      end
      BURST: begin
        // write low stalls: ptr and cnt hold until the writer resumes
        if (write) begin
          wr_en  = 1'b1;
          wr_idx = ptr_q;
          ptr_d  = ptr_q + 3'd1;
          cnt_d  = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    slot_d  = slot_q;
    // a same-edge write wins over clear for its own slot
    valid_d = clear ? 8'h00 : valid_q;
    if (wr_en) begin
      slot_d[wr_idx]  = din;
      valid_d[wr_idx] = 1'b1;
    end

    busy_d = (state_d == BURST);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      valid_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a     = slot_q[0];
  assign b     = slot_q[1];
  assign c     = slot_q[2];
  assign d     = slot_q[3];
  assign e     = slot_q[4];
  assign f     = slot_q[5];
  assign g     = slot_q[6];
  assign h     = slot_q[7];
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_demux_wr.sv
// Directed bench for demux_wr: single writes, bursts with wrap and stall, clear,
// mid-burst async reset and a one-word burst.
module tb_demux_wr;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             write, burst, clear;
  logic [2:0]       s, len;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
  logic [7:0]       valid;
  logic             busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux_wr #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .write(write), .burst(burst), .s(s), .len(len),
    .clear(clear), .din(din),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .valid(valid), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; write = 1'b0; burst = 1'b0; clear = 1'b0;
    s = 3'd0; len = 3'd0; din = '0;
    step(); step();
    chk("rst_a", a, 0);  chk("rst_h", h, 0);
    chk("rst_valid", valid, 8'h00);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    rst_n = 1'b1;
    step();

    // 1: single write
    write = 1'b1; s = 3'd3; din = 16'hBEEF;
    step();
    write = 1'b0;
    chk("t1_d", d, 16'hBEEF); chk("t1_a", a, 0); chk("t1_e", e, 0);
    chk("t1_valid", valid, 8'b0000_1000); chk("t1_busy", busy, 0);

    // 2: burst of 4 from slot 6, wraps 7->0
    write = 1'b1; burst = 1'b1; s = 3'd6; len = 3'd3; din = 16'd1;
    step();
    chk("t2_busy", busy, 1);
    burst = 1'b0; s = 3'd0; din = 16'd2; step();
    din = 16'd3; step();
    din = 16'd4; step();
    write = 1'b0;
    chk("t2_done", done, 1); chk("t2_busy_done", busy, 0);
    step();
    chk("t2_done_off", done, 0);
    chk("t2_g", g, 1); chk("t2_h", h, 2); chk("t2_a", a, 3); chk("t2_b", b, 4);
    chk("t2_valid", valid, 8'b1100_1011);

    // 3: burst of 3 from slot 0 with a two-cycle stall after the first word
    write = 1'b1; burst = 1'b1; s = 3'd0; len = 3'd2; din = 16'h0010;
    step();
    write = 1'b0; burst = 1'b0;
    step();
    chk("t3_stall_busy0", busy, 1);
    step();
    chk("t3_stall_busy1", busy, 1); chk("t3_stall_b", b, 4);
    write = 1'b1; din = 16'h0011; step();
    chk("t3_busy", busy, 1);
    din = 16'h0012; step();
    write = 1'b0;
    chk("t3_done", done, 1);
    step();
    chk("t3_done_off", done, 0); chk("t3_busy_off", busy, 0);
    chk("t3_a", a, 16'h0010); chk("t3_b", b, 16'h0011); chk("t3_c", c, 16'h0012);
    chk("t3_d", d, 16'hBEEF);

    // 4: clear together with a single write
    clear = 1'b1; write = 1'b1; s = 3'd5; din = 16'h00AA;
    step();
    clear = 1'b0; write = 1'b0;
    chk("t4_valid", valid, 8'b0010_0000);
    chk("t4_f", f, 16'h00AA); chk("t4_d", d, 16'hBEEF); chk("t4_g", g, 1);

    // 5: async reset mid-way through an 8-word burst
    write = 1'b1; burst = 1'b1; s = 3'd2; len = 3'd7; din = 16'h0100;
    step();
    burst = 1'b0; din = 16'h0101; step();
    din = 16'h0102; step();
    chk("t5_e_pre", e, 16'h0102); chk("t5_busy_pre", busy, 1);
    write = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_a", a, 0); chk("t5_c", c, 0); chk("t5_e", e, 0); chk("t5_f", f, 0);
    chk("t5_valid", valid, 8'h00); chk("t5_busy", busy, 0);
    step();
    rst_n = 1'b1;
    step();
    write = 1'b1; s = 3'd1; din = 16'h5555;
    step();
    write = 1'b0;
    chk("t5_b_after", b, 16'h5555); chk("t5_valid_after", valid, 8'b0000_0010);
    chk("t5_busy_after", busy, 0);

    // 6: one-word burst at slot 7; a write during DONE is dropped
    write = 1'b1; burst = 1'b1; s = 3'd7; len = 3'd0; din = 16'h1234;
    step();
    chk("t6_h", h, 16'h1234); chk("t6_busy", busy, 0); chk("t6_done", done, 1);
    burst = 1'b0; s = 3'd0; din = 16'hFFFF;
    step();
    write = 1'b0;
    chk("t6_done_off", done, 0); chk("t6_busy_off", busy, 0);
    chk("t6_a_ignored", a, 0); chk("t6_valid", valid, 8'b1000_0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
